// File: rtl/cp0_pkg.sv
// Shared CP0 definitions for the MIPS datapath and control.
// Holds register indices, operation codes, STATUS/CAUSE field positions and reset constants.
package cp0_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_MTC0 = 2'd1,
        OP_ERET = 2'd2,
        OP_RSVD = 2'd3
    } cp0_op_e;

    localparam logic [4:0]  CPR_COUNT   = 5'd9;
    localparam logic [4:0]  CPR_COMPARE = 5'd11;
    localparam logic [4:0]  CPR_STATUS  = 5'd12;
    localparam logic [4:0]  CPR_CAUSE   = 5'd13;
    localparam logic [4:0]  CPR_EPC     = 5'd14;
    localparam logic [4:0]  CPR_EHBR    = 5'd15;

    localparam int          ST_IE       = 0;
    localparam int          ST_EXL      = 1;
    localparam int          ST_IM_LO    = 8;
    localparam int          CA_IP_LO    = 8;

    localparam logic [31:0] HANDLER_RST = 32'h0000_0008;
    localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

    // Bit 0 of IM/IP is the external line, bit 1 the timer.
    function automatic logic [31:0] pack_status(input logic [1:0] im, input logic exl, input logic ie);
        return {22'd0, im, 6'd0, exl, ie};
    endfunction

    function automatic logic [31:0] pack_cause(input logic [1:0] ip);
        return {22'd0, ip, 8'd0};
    endfunction

endpackage

// File: rtl/cp0_if.sv
// ID-stage to CP0 bus: instruction operation, register access, interrupt line and PC redirect.
interface cp0_if;
    logic [1:0]  oper;
    logic        en;
    logic        ir_en;
    logic [4:0]  addr_cpr;
    logic [31:0] data_w_cpr;
    logic [31:0] data_r_cpr;
    logic [31:0] ret_addr;
    logic        ir_in;
    logic        jump_en;
    logic [31:0] jump_addr;

    modport master (
        output oper, en, ir_en, addr_cpr, data_w_cpr, ret_addr, ir_in,
        input  data_r_cpr, jump_en, jump_addr
    );

    modport slave (
        input  oper, en, ir_en, addr_cpr, data_w_cpr, ret_addr, ir_in,
        output data_r_cpr, jump_en, jump_addr
    );
endinterface

// File: rtl/cp0_timer.sv
// COUNT/COMPARE timer of CP0 with the timer pending bit (CAUSE.IP[9]).
// A COMPARE write clears the pending bit and beats a same-cycle match; a match beats acceptance.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr_count,
    input  logic        i_wr_compare,
    input  logic [31:0] i_wdata,
    input  logic        i_ack,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ip
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ip;
    logic        w_match;

    assign w_match   = (r_count == r_compare);
    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ip      = r_ip;

    // Free-running counter, compare register and timer request latch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count   <= 32'd0;
            r_compare <= COMPARE_RST;
            r_ip      <= 1'b0;
        end else begin
            if (i_wr_count) begin
                r_count <= i_wdata;
            end else begin
                r_count <= r_count + 32'd1;
            end

            if (i_wr_compare) begin
                r_compare <= i_wdata;
            end else begin
                r_compare <= r_compare;
            end

            if (i_wr_compare) begin
                r_ip <= 1'b0;
            end else if (w_match) begin
                r_ip <= 1'b1;
            end else if (i_ack) begin
                r_ip <= 1'b0;
            end else begin
                r_ip <= r_ip;
            end
        end
    end

endmodule

// File: rtl/cp0.sv
// Coprocessor 0: exception state, interrupt latching and acceptance, MTC0/MFC0/ERET,
// and the forced-jump pair that redirects the fetch PC.
module cp0
    import cp0_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    cp0_if.slave  io_bus
);

    logic        r_ie;
    logic        r_exl;
    logic [1:0]  r_im;
    logic        r_ip_ext;
    logic [31:0] r_epc;
    logic [31:0] r_ehbr;
    logic        r_ir_prev;

    logic        w_mtc0;
    logic        w_eret;
    logic        w_wr_status;
    logic        w_wr_epc;
    logic        w_wr_ehbr;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_ip_tmr;
    logic [1:0]  w_ip;
    logic [1:0]  w_pend;
    logic        w_take;
    logic        w_take_ext;
    logic        w_take_tmr;
    logic        w_ir_rise;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic [31:0] w_rdata;
    logic        w_jump_en;
    logic [31:0] w_jump_addr;

    assign w_mtc0       = io_bus.en & (io_bus.oper == OP_MTC0);
    assign w_eret       = io_bus.en & (io_bus.oper == OP_ERET);
    assign w_wr_status  = w_mtc0 & (io_bus.addr_cpr == CPR_STATUS);
    assign w_wr_epc     = w_mtc0 & (io_bus.addr_cpr == CPR_EPC);
    assign w_wr_ehbr    = w_mtc0 & (io_bus.addr_cpr == CPR_EHBR);
    assign w_wr_count   = w_mtc0 & (io_bus.addr_cpr == CPR_COUNT);
    assign w_wr_compare = w_mtc0 & (io_bus.addr_cpr == CPR_COMPARE);

    assign w_ip      = {w_ip_tmr, r_ip_ext};
    assign w_pend    = w_ip & r_im;
    assign w_ir_rise = io_bus.ir_in & ~r_ir_prev;

    // ERET masks entry; the external source wins when both are pending.
    assign w_take     = r_ie & ~r_exl & (|w_pend) & io_bus.ir_en & ~w_eret;
    assign w_take_ext = w_take & w_pend[0];
    assign w_take_tmr = w_take & ~w_pend[0];

    cp0_timer u_timer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_wr_count   (w_wr_count),
        .i_wr_compare (w_wr_compare),
        .i_wdata      (io_bus.data_w_cpr),
        .i_ack        (w_take_tmr),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_ip         (w_ip_tmr)
    );

    // MFC0 read port.
    always_comb begin
        w_rdata = 32'd0;
        case (io_bus.addr_cpr)
            CPR_COUNT:   w_rdata = w_count;
            CPR_COMPARE: w_rdata = w_compare;
            CPR_STATUS:  w_rdata = pack_status(r_im, r_exl, r_ie);
            CPR_CAUSE:   w_rdata = pack_cause(w_ip);
            CPR_EPC:     w_rdata = r_epc;
            CPR_EHBR:    w_rdata = r_ehbr;
            default:     w_rdata = 32'd0;
        endcase
    end

    // PC redirect for ERET or interrupt entry.
    always_comb begin
        w_jump_en   = 1'b0;
        w_jump_addr = 32'd0;
        if (w_eret) begin
            w_jump_en   = 1'b1;
            w_jump_addr = r_epc;
        end else if (w_take) begin
            w_jump_en   = 1'b1;
            w_jump_addr = r_ehbr;
        end else begin
            w_jump_en   = 1'b0;
            w_jump_addr = 32'd0;
        end
    end

    assign io_bus.data_r_cpr = w_rdata;
    assign io_bus.jump_en    = w_jump_en;
    assign io_bus.jump_addr  = w_jump_addr;

    // STATUS: hardware updates on entry/return override a same-cycle MTC0 on EXL.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ie  <= 1'b0;
            r_exl <= 1'b0;
            r_im  <= 2'b00;
        end else begin
            if (w_take) begin
                r_exl <= 1'b1;
                r_ie  <= w_wr_status ? io_bus.data_w_cpr[ST_IE] : r_ie;
            end else if (w_eret) begin
                r_exl <= 1'b0;
                r_ie  <= 1'b1;
            end else if (w_wr_status) begin
                r_exl <= io_bus.data_w_cpr[ST_EXL];
                r_ie  <= io_bus.data_w_cpr[ST_IE];
            end else begin
                r_exl <= r_exl;
                r_ie  <= r_ie;
            end

            if (w_wr_status) begin
                r_im <= io_bus.data_w_cpr[ST_IM_LO +: 2];
            end else begin
                r_im <= r_im;
            end
        end
    end

    // EPC, handler base, external request latch and its edge-detector history.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_epc     <= 32'd0;
            r_ehbr    <= HANDLER_RST;
            r_ip_ext  <= 1'b0;
            r_ir_prev <= 1'b0;
        end else begin
            if (w_take) begin
                r_epc <= io_bus.ret_addr;
            end else if (w_wr_epc) begin
                r_epc <= io_bus.data_w_cpr;
            end else begin
                r_epc <= r_epc;
            end

            if (w_wr_ehbr) begin
                r_ehbr <= io_bus.data_w_cpr;
            end else begin
                r_ehbr <= r_ehbr;
            end

            if (w_ir_rise) begin
                r_ip_ext <= 1'b1;
            end else if (w_take_ext) begin
                r_ip_ext <= 1'b0;
            end else begin
                r_ip_ext <= r_ip_ext;
            end

            r_ir_prev <= io_bus.ir_in;
        end
    end

endmodule
